// File: rtl/bin_to_bcd_seq_if.sv
// Start/valid handshake bundle between the DIP-word slicer and the
// binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4
);
  logic                  i_Start;
  logic [BIN_W-1:0]      i_Bin;
  logic                  o_Busy;
  logic                  o_Valid;
  logic [4*DIGITS-1:0]   o_BCD;
  logic [DIGITS-1:0]     o_Blank;
  logic                  o_Ovf;

  // Requester side: issues start and operand, observes the result.
  modport master (
    output i_Start, i_Bin,
    input  o_Busy, o_Valid, o_BCD, o_Blank, o_Ovf
  );

  // Converter side.
  modport slave (
    input  i_Start, i_Bin,
    output o_Busy, o_Valid, o_BCD, o_Blank, o_Ovf
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble (shift-add-3) converter: unsigned binary in,
// packed BCD digits plus a leading-zero blank mask out. One bit is
// consumed per clock, so a conversion takes BIN_W cycles after the start
// edge. Values that do not fit in DIGITS digits saturate to all nines.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4
) (
  input  logic            i_CLK,
  input  logic            i_RESET,
  bin_to_bcd_seq_if.slave conv
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // 10^n evaluated at elaboration time.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned LIMIT     = pow10(DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Add-3 correction: any digit >= 5 would exceed 9 after doubling.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int k = 0; k < DIGITS; k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Leading-zero mask: digit k (k >= 1) blanks when it and every digit
  // above it are zero; the units digit always shows.
  function automatic logic [DIGITS-1:0] blank_of(input logic [BCD_W-1:0] b);
    logic [DIGITS-1:0] m;
    logic              zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (b[4*k +: 4] == 4'd0);
      m[k]       = zero_above;
    end
    return m;
  endfunction

  state_t             state_q,   state_d;
  logic [BIN_W-1:0]   shift_q,   shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               ovf_cap_q, ovf_cap_d;
  logic [BCD_W-1:0]   bcd_q,     bcd_d;
  logic [DIGITS-1:0]  blank_q,   blank_d;
  logic               ovf_q,     ovf_d;
  logic               valid_q,   valid_d;

  // Next-state and datapath: capture on start, shift-add-3 while busy,
  // commit results on the edge that completes the last shift.
  always_comb begin
    // NOTE: every _d signal gets its hold value first so no branch can leave one unassigned and infer a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ovf_cap_d = ovf_cap_q;
    bcd_d     = bcd_q;
    blank_d   = blank_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (conv.i_Start) begin
          state_d   = S_SHIFT;
          shift_d   = conv.i_Bin;
          scratch_d = '0;
          cnt_d     = '0;
          // Range check happens on the operand as captured, not at commit.
          ovf_cap_d = (64'(conv.i_Bin) >= LIMIT);
        end
      end

      S_SHIFT: begin
        // Correct the digits, then move the next binary bit into digit 0.
        {scratch_d, shift_d} = {add3(scratch_q), shift_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_IDLE;
          valid_d = 1'b1;
          ovf_d   = ovf_cap_q;
          bcd_d   = ovf_cap_q ? ALL_NINES : scratch_d;
          blank_d = blank_of(bcd_d);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any conversion in flight.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      // NOTE: the shift datapath is reset too, so a stale operand can never leak into a later result.
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_cap_q <= 1'b0;
      bcd_q     <= '0;
      blank_q   <= BLANK_RST;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples values from before the edge.
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_cap_q <= ovf_cap_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign conv.o_Busy  = (state_q == S_SHIFT);
  assign conv.o_Valid = valid_q;
  assign conv.o_BCD   = bcd_q;
  assign conv.o_Blank = blank_q;
  assign conv.o_Ovf   = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a default 13-bit instance and a
// 14-bit instance that can overflow four digits.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(13), .DIGITS(4)) b13 ();
  bin_to_bcd_seq_if #(.BIN_W(14), .DIGITS(4)) b14 ();

  bin_to_bcd_seq #(.BIN_W(13), .DIGITS(4)) dut (
    .i_CLK   (clk),
    .i_RESET (rst),
    .conv    (b13)
  );

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut14 (
    .i_CLK   (clk),
    .i_RESET (rst),
    .conv    (b14)
  );

  // Selects which instance the helper tasks talk to.
  bit          sel14 = 1'b0;
  logic        m_valid, m_busy, m_ovf;
  logic [15:0] m_bcd;
  logic [3:0]  m_blank;

  assign m_valid = sel14 ? b14.o_Valid : b13.o_Valid;
  assign m_busy  = sel14 ? b14.o_Busy  : b13.o_Busy;
  assign m_ovf   = sel14 ? b14.o_Ovf   : b13.o_Ovf;
  assign m_bcd   = sel14 ? b14.o_BCD   : b13.o_BCD;
  assign m_blank = sel14 ? b14.o_Blank : b13.o_Blank;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, blanking by magnitude.
  function automatic void model(input int unsigned v, output logic [15:0] bcd,
                                output logic [3:0] blank, output logic ovf);
    int unsigned p;
    ovf   = (v >= 10000);
    bcd   = 16'h9999;
    blank = 4'b0000;
    if (!ovf) begin
      p = 1;
      for (int k = 0; k < 4; k++) begin
        bcd[4*k +: 4] = 4'((v / p) % 10);
        blank[k]      = (k != 0) && (v < p);
        p             = p * 10;
      end
    end
  endfunction

  task automatic drive(input bit start, input int unsigned v);
    if (sel14) begin
      b14.i_Start = start;
      b14.i_Bin   = 14'(v);
    end else begin
      b13.i_Start = start;
      b13.i_Bin   = 13'(v);
    end
  endtask

  // Advance one clock; returns at the falling edge (sampling point).
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full conversion checked against the model, including latency and
  // a single-cycle valid pulse.
  task automatic run_conv(input int unsigned v, input string tag);
    logic [15:0] e_bcd;
    logic [3:0]  e_blank;
    logic        e_ovf;
    int          lat;
    model(v, e_bcd, e_blank, e_ovf);
    drive(1'b1, v);
    cyc();
    drive(1'b0, $urandom);
    check({tag, " busy"}, 32'(m_busy), 1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (m_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, lat, sel14 ? 14 : 13);
    check({tag, " bcd"},   32'(m_bcd),   32'(e_bcd));
    check({tag, " blank"}, 32'(m_blank), 32'(e_blank));
    check({tag, " ovf"},   32'(m_ovf),   32'(e_ovf));
    check({tag, " idle at valid"}, 32'(m_busy), 0);
    cyc();
    check({tag, " valid one cycle"}, 32'(m_valid), 0);
  endtask

  typedef struct {
    int unsigned bin;
    logic [15:0] bcd;
    logic [3:0]  blank;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int nval, first, last;
    logic [15:0] got;

    vecs[0] = '{8191, 16'h8191, 4'b0000};
    vecs[1] = '{0,    16'h0000, 4'b1110};
    vecs[2] = '{7,    16'h0007, 4'b1110};
    vecs[3] = '{40,   16'h0040, 4'b1100};
    vecs[4] = '{999,  16'h0999, 4'b1000};
    vecs[5] = '{10,   16'h0010, 4'b1100};
    vecs[6] = '{1000, 16'h1000, 4'b0000};
    vecs[7] = '{4095, 16'h4095, 4'b0000};

    rst = 1'b1;
    b13.i_Start = 1'b0; b13.i_Bin = '0;
    b14.i_Start = 1'b0; b14.i_Bin = '0;
    cyc(); cyc(); cyc();
    check("reset busy",  32'(b13.o_Busy),  0);
    check("reset valid", 32'(b13.o_Valid), 0);
    check("reset bcd",   32'(b13.o_BCD),   0);
    check("reset blank", 32'(b13.o_Blank), 32'b1110);
    check("reset ovf",   32'(b13.o_Ovf),   0);
    rst = 1'b0;
    cyc();

    // Table: fixed operands with hand-derived results.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].bin);
      cyc();
      drive(1'b0, 0);
      nval = 0;
      first = 0;
      for (int k = 1; k <= 40 && nval == 0; k++) begin
        cyc();
        if (m_valid) begin
          nval  = 1;
          first = k;
        end
      end
      check($sformatf("vec%0d latency", i), first, 13);
      check($sformatf("vec%0d bcd", i),   32'(m_bcd),   32'(vecs[i].bcd));
      check($sformatf("vec%0d blank", i), 32'(m_blank), 32'(vecs[i].blank));
      check($sformatf("vec%0d ovf", i),   32'(m_ovf),   0);
      cyc();
    end

    // Start during a conversion is dropped, not queued.
    drive(1'b1, 1000);
    cyc();
    drive(1'b0, 1000);
    nval = 0; first = 0; got = '0;
    for (int k = 1; k <= 35; k++) begin
      cyc();
      if (m_valid) begin
        nval++;
        if (first == 0) begin
          first = k;
          got   = m_bcd;
        end
      end
      if (k == 3) drive(1'b1, 5);
      if (k == 4) drive(1'b0, 5);
    end
    check("ignored start count",   nval, 1);
    check("ignored start latency", first, 13);
    check("ignored start bcd",     32'(got), 32'h1000);

    // Start held high: back-to-back, next start accepted on the valid cycle.
    drive(1'b1, 1);
    cyc();
    nval = 0; last = 0;
    for (int k = 1; k <= 60 && nval < 3; k++) begin
      cyc();
      if (m_valid) begin
        nval++;
        check($sformatf("b2b%0d bcd", nval), 32'(m_bcd), nval);
        check($sformatf("b2b%0d gap", nval), k - last, (nval == 1) ? 13 : 14);
        last = k;
        drive(nval < 3, nval + 1);
      end
    end
    check("b2b count", nval, 3);
    cyc();
    check("b2b ends idle", 32'(m_busy), 0);
    cyc();

    // Random operands over the full 13-bit range.
    for (int i = 0; i < 30; i++) run_conv($urandom_range(8191, 0), $sformatf("rnd13_%0d", i));

    // Wide instance: overflow saturation and the largest in-range value.
    sel14 = 1'b1;
    cyc();
    run_conv(12000, "ovf12000");
    run_conv(9999,  "max9999");
    for (int i = 0; i < 10; i++) run_conv($urandom_range(16383, 0), $sformatf("rnd14_%0d", i));
    run_conv(15000, "ovf15000");

    // Reset in the middle of a conversion.
    sel14 = 1'b0;
    run_conv(8191, "pre-reset");
    drive(1'b1, 1234);
    cyc();
    drive(1'b0, 1234);
    nval = 0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      nval += int'(m_valid);
    end
    rst = 1'b1;
    #1;
    check("midrst busy",   32'(b13.o_Busy),  0);
    check("midrst bcd",    32'(b13.o_BCD),   0);
    check("midrst blank",  32'(b13.o_Blank), 32'b1110);
    check("midrst ovf",    32'(b13.o_Ovf),   0);
    check("midrst ovf14",  32'(b14.o_Ovf),   0);
    cyc(); cyc();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      nval += int'(m_valid);
    end
    check("midrst no valid", nval, 0);
    check("midrst stays idle", 32'(b13.o_Busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential shift-add-3 (double-dabble) converter from unsigned binary to packed BCD.
- Sits directly upstream of the seven-segment display driver. It takes the 13-bit value sliced from the parallelized DIP word and delivers 4 BCD digits plus a leading-zero blank mask.
- Clocked from the 100 MHz domain. Runs one conversion per start request using a start/valid handshake.

Parameters:
- BIN_W, 13, width of binary input.
- DIGITS, 4, number of BCD digits produced (o_BCD width = 4*DIGITS).

Ports:
- i_CLK  in  1  conversion clock; all logic on rising edge.
- i_RESET  in  1  asynchronous, active-high reset.
- i_Start  in  1  conversion request, sampled on the rising edge.
- i_Bin  in  BIN_W  unsigned binary operand; captured on the accepted-start edge only.
- o_Busy  out  1  high while a conversion is in progress.
- o_Valid  out  1  one-cycle pulse: o_BCD, o_Blank and o_Ovf were updated this cycle.
- o_BCD  out  4*DIGITS  packed BCD result; digit 0 is at [3:0]; held between conversions.
- o_Blank  out  DIGITS  bit k=1: digit k is a leading zero and is to be blanked.
- o_Ovf  out  1  last captured value was >= 10^DIGITS.

Behaviour:
- Reset (async, any time, including mid-conversion):
  - State is IDLE and the conversion is aborted.
  - o_BCD=0, o_Valid=0, o_Busy=0, o_Ovf=0.
  - o_Blank={(DIGITS-1){1}, 0}.
- FSM states:
  - IDLE: i_Start=1 at an edge -> capture i_Bin into the shift register, clear the BCD scratch, set bit counter=0, set o_Busy=1, go to SHIFT. i_Start=0 -> stay.
  - SHIFT: on each edge, first add 3 to every scratch digit >=5, then left-shift {scratch, shift reg} by 1 and increment the counter. On the edge that completes shift BIN_W: go to IDLE, set o_Busy=0, set o_Valid=1, and commit the outputs.
- Latency:
  - Start accepted at edge N -> o_Valid high for exactly the cycle after edge N+BIN_W (13 cycles at default).
  - Earliest next start is accepted at edge N+BIN_W+1, which is the same edge o_Valid drops. The bench must accept a start while o_Valid=1.
- i_Start while SHIFT: ignored, with no queuing. i_Bin changes after capture have no effect.
- i_Start held high continuously: back-to-back conversions, one every BIN_W+1 cycles.
- Overflow:
  - 10^DIGITS is a localparam. The captured value is compared against it on the capture edge and the flag is registered internally.
  - On commit with overflow: o_Ovf=1, o_BCD=all digits 9, o_Blank=0.
  - Otherwise o_Ovf=0 and o_BCD=scratch.
  - At the defaults (max 8191) overflow never occurs.
- Blank mask, computed from the committed digits:
  - For k>=1, bit k=1 iff digit k and every digit above it are 0.
  - Bit 0 is always 0.
- o_BCD, o_Blank and o_Ovf change only on commit edges or reset. o_Valid is never high for 2 consecutive cycles unless a start is accepted on the valid edge of the previous conversion.
- Internal scratch holds DIGITS digits. The bit counter is wide enough for BIN_W.

Test Plan:
1. Reset mid-conversion: assert i_RESET 5 cycles after a start with i_Bin=1234 -> o_Busy=0 immediately, o_BCD=0, o_Blank=4'b1110, and no o_Valid pulse.
2. i_Bin=8191, pulse i_Start -> o_Valid exactly 13 cycles after the start edge, o_BCD=16'h8191, o_Blank=0, o_Ovf=0. Repeat with i_Bin=0 -> o_BCD=0, o_Blank=4'b1110.
3. i_Bin=7, then i_Bin=40 -> o_BCD=16'h0007 with o_Blank=4'b1110; then o_BCD=16'h0040 with o_Blank=4'b1100.
4. Start accepted with i_Bin=1000. Change i_Bin to 5 and pulse i_Start at cycle 4 -> single result 16'h1000, and the second pulse is ignored.
5. i_Start held high, i_Bin stepping 1,2,3 -> o_Valid every 14 cycles, results 0001, 0002, 0003.
6. Override BIN_W=14 and apply i_Bin=12000 -> o_Ovf=1, o_BCD=16'h9999, o_Blank=0. Follow with 9999 -> o_Ovf=0, o_BCD=16'h9999.
